// File: rtl/interrupter_burst.sv
// DRSSTC interrupter: arithmetic period, burst modulation, OCD lockout with trip
// counting and latched fault. Gate drive changes only on gen rising edges.
module interrupter_burst #(
  parameter  int CLK_MHZ      = 100,
  parameter  int FREQ_MIN_HZ  = 10_000,
  parameter  int PAR_MAX_VAL  = 255,
  parameter  int PW_STEP_MUL  = 1,
  parameter  int SKIP_CNT_MAX = 3,
  parameter  int FAULT_TRIPS  = 4,
  parameter  int BURST_MAX    = 15,
  parameter  int SYNC_STAGES  = 2,
  localparam int W_PAR        = $clog2(PAR_MAX_VAL + 1),
  localparam int W_BURST      = $clog2(BURST_MAX + 1)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               gen_i,
  input  logic               ocd_i,
  input  logic               en_i,
  input  logic               mode_i,
  input  logic [W_PAR-1:0]   freq_par_i,
  input  logic [W_PAR-1:0]   pw_par_i,
  input  logic [W_BURST-1:0] burst_on_i,
  input  logic [W_BURST-1:0] burst_off_i,
  input  logic               fault_clr_i,
  output logic               out_p_o,
  output logic               out_n_o,
  output logic               int_out_o,
  output logic               lockout_o,
  output logic               fault_o
);

  localparam int FREQ_RATIO = CLK_MHZ * 1_000_000 / FREQ_MIN_HZ;
  localparam int PER_STEP   = FREQ_RATIO / (PAR_MAX_VAL + 1);
  localparam int W_PER      = $clog2(FREQ_RATIO + 1);
  localparam int W_PWC      = W_PAR + W_PER;
  localparam int W_SKIP     = $clog2(SKIP_CNT_MAX + 1);
  localparam int W_TRIP     = $clog2(FAULT_TRIPS + 1);
  localparam logic [W_SKIP-1:0] SKIP_RELOAD = W_SKIP'(SKIP_CNT_MAX);
  localparam logic [W_TRIP-1:0] TRIP_LIMIT  = W_TRIP'(FAULT_TRIPS);

  typedef enum logic [1:0] {S_RUN, S_LOCKOUT, S_FAULT} state_t;

  state_t               state_q;
  logic [SYNC_STAGES-1:0] ocd_sync_q;
  logic                 ocd_s, ocd_s_q, ocd_rise;
  logic                 gen_q, gen_rise;
  logic                 init_q;
  logic [W_PER-1:0]     period_q, pw_q, phase_q, phase_d;
  logic [W_BURST-1:0]   bon_q, boff_q, burst_idx_q, burst_idx_d;
  logic                 mode_q;
  logic                 ocd_seen_q, ocd_seen_d;
  logic                 load, wrap, int_on, burst_act, int_out;
  logic [W_PER-1:0]     per_calc, pw_sel;
  logic [W_PWC-1:0]     pw_calc;
  logic [W_BURST:0]     burst_sum;
  logic                 ff_q, lockout_q, fault_q;
  logic [W_SKIP-1:0]    skip_cnt_q;
  logic [W_TRIP-1:0]    trip_cnt_q, trip_inc;

  assign ocd_s    = ocd_sync_q[SYNC_STAGES-1];
  assign ocd_rise = ocd_s & ~ocd_s_q;
  assign gen_rise = gen_i & ~gen_q;

  assign per_calc = W_PER'(FREQ_RATIO) - W_PER'(freq_par_i) * W_PER'(PER_STEP);
  assign pw_calc  = W_PWC'(pw_par_i) * W_PWC'(PW_STEP_MUL);
  assign pw_sel   = (pw_calc < W_PWC'(per_calc)) ? pw_calc[W_PER-1:0] : per_calc;

  // Parameters are sampled only at a period boundary (or while idle) so a window never glitches.
  assign wrap = init_q & en_i & (phase_q + W_PER'(1) >= period_q);
  assign load = ~init_q | ~en_i | wrap;

  assign burst_sum = {1'b0, bon_q} + {1'b0, boff_q};
  assign int_on    = phase_q < pw_q;
  assign burst_act = ~mode_q | (burst_idx_q < bon_q);
  assign int_out   = en_i & int_on & burst_act & (state_q == S_RUN);
  assign trip_inc  = (trip_cnt_q == TRIP_LIMIT) ? trip_cnt_q : trip_cnt_q + W_TRIP'(1);

  always_comb begin
    phase_d     = phase_q;
    burst_idx_d = burst_idx_q;
    ocd_seen_d  = ocd_seen_q | ocd_s;
    if (!init_q || !en_i) begin
      phase_d     = '0;
      burst_idx_d = '0;
    end else if (wrap) begin
      phase_d    = '0;
      ocd_seen_d = ocd_s;
      if (!mode_i || burst_sum == '0 ||
          ({1'b0, burst_idx_q} + (W_BURST+1)'(1) >= burst_sum))
        burst_idx_d = '0;
      else
        burst_idx_d = burst_idx_q + W_BURST'(1);
    end else begin
      phase_d = phase_q + W_PER'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ocd_sync_q  <= '0;
      ocd_s_q     <= 1'b0;
      gen_q       <= 1'b0;
      init_q      <= 1'b0;
      phase_q     <= '0;
      burst_idx_q <= '0;
      ocd_seen_q  <= 1'b0;
      period_q    <= '0;
      pw_q        <= '0;
      bon_q       <= '0;
      boff_q      <= '0;
      mode_q      <= 1'b0;
    end else begin
      ocd_sync_q  <= {ocd_sync_q[SYNC_STAGES-2:0], ocd_i};
      ocd_s_q     <= ocd_s;
      gen_q       <= gen_i;
      init_q      <= 1'b1;
      phase_q     <= phase_d;
      burst_idx_q <= burst_idx_d;
      ocd_seen_q  <= ocd_seen_d;
      if (load) begin
        period_q <= per_calc;
        pw_q     <= pw_sel;
        bon_q    <= burst_on_i;
        boff_q   <= burst_off_i;
        mode_q   <= mode_i;
      end
    end
  end

  // state   | meaning
  // S_RUN   | gate follows the interrupter window on gen rising edges
  // S_LOCKOUT | gate held off for SKIP_CNT_MAX gen rises after an OCD event
  // S_FAULT | too many consecutive trips; gate off until fault_clr
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_RUN;
      ff_q       <= 1'b0;
      skip_cnt_q <= SKIP_RELOAD;
      trip_cnt_q <= '0;
      lockout_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (ocd_s) begin
            trip_cnt_q <= trip_inc;
            skip_cnt_q <= SKIP_RELOAD;
            if (gen_rise) ff_q <= 1'b0;
            if (trip_inc == TRIP_LIMIT) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
              ff_q    <= 1'b0;
            end else begin
              state_q   <= S_LOCKOUT;
              lockout_q <= 1'b1;
            end
          end else begin
            if (gen_rise) ff_q <= int_out;
            if (wrap && !ocd_seen_q) trip_cnt_q <= '0;
          end
        end
        S_LOCKOUT: begin
          if (gen_rise) begin
            ff_q <= 1'b0;
            if (skip_cnt_q != '0) skip_cnt_q <= skip_cnt_q - W_SKIP'(1);
          end
          if (ocd_rise) begin
            skip_cnt_q <= SKIP_RELOAD;
            trip_cnt_q <= trip_inc;
            if (trip_inc == TRIP_LIMIT) begin
              state_q   <= S_FAULT;
              fault_q   <= 1'b1;
              lockout_q <= 1'b0;
              ff_q      <= 1'b0;
            end
          end else if (skip_cnt_q == '0 && !ocd_s) begin
            state_q   <= S_RUN;
            lockout_q <= 1'b0;
          end
        end
        S_FAULT: begin
          ff_q <= 1'b0;
          if (fault_clr_i && !ocd_s) begin
            state_q    <= S_RUN;
            fault_q    <= 1'b0;
            trip_cnt_q <= '0;
            skip_cnt_q <= SKIP_RELOAD;
          end
        end
        default: begin
          state_q   <= S_RUN;
          lockout_q <= 1'b0;
          fault_q   <= 1'b0;
          ff_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_p_o   = ff_q & gen_q;
  assign out_n_o   = ff_q & ~gen_q;
  assign int_out_o = int_out;
  assign lockout_o = lockout_q;
  assign fault_o   = fault_q;

endmodule

// File: tb/tb_interrupter_burst.sv
// Directed bench for interrupter_burst: table of window configurations plus
// hand-written OCD, fault, reset and enable sequences.
module tb_interrupter_burst;

  logic       clk, rst_n, gen, ocd, en, mode, fault_clr;
  logic [7:0] fp, pw;
  logic [3:0] bon, boff;
  logic       out_p, out_n, int_out, lockout, fault;
  logic       gen_auto, gen_man, gen_tog;
  int         gcnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] fp;
    logic [7:0] pw;
    logic       mode;
    logic [3:0] bon;
    logic [3:0] boff;
    int         win;
    int         exp_cnt;
    int         exp_rise;
  } vec_t;

  vec_t vecs[9];

  interrupter_burst dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .gen_i       (gen),
    .ocd_i       (ocd),
    .en_i        (en),
    .mode_i      (mode),
    .freq_par_i  (fp),
    .pw_par_i    (pw),
    .burst_on_i  (bon),
    .burst_off_i (boff),
    .fault_clr_i (fault_clr),
    .out_p_o     (out_p),
    .out_n_o     (out_n),
    .int_out_o   (int_out),
    .lockout_o   (lockout),
    .fault_o     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 500 kHz gen square wave (100 cycles per half period) for the table runs
  always @(negedge clk) begin
    if (gen_auto) begin
      if (gcnt == 99) begin
        gcnt    <= 0;
        gen_tog <= ~gen_tog;
      end else begin
        gcnt <= gcnt + 1;
      end
    end else begin
      gcnt    <= 0;
      gen_tog <= 1'b0;
    end
  end
  assign gen = gen_auto ? gen_tog : gen_man;

  task automatic check(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic gen_cycle(output logic p);
    @(negedge clk); gen_man = 1'b1;
    @(posedge clk); #1; p = out_p;
    repeat (4) @(posedge clk);
    @(negedge clk); gen_man = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic ocd_pulse();
    @(negedge clk); ocd = 1'b1;
    @(negedge clk); ocd = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] f, input logic [7:0] p);
    rst_n = 1'b0;
    fp = f; pw = p; mode = 1'b0; bon = '0; boff = '0; en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int   cnt, rise, both;
  logic s, prev, p;

  initial begin
    rst_n = 1'b0; ocd = 1'b0; en = 1'b1; mode = 1'b0; fault_clr = 1'b0;
    fp = '0; pw = '0; bon = '0; boff = '0; gen_auto = 1'b0; gen_man = 1'b0;

    //                fp     pw    mode  on    off   win    cnt  rise
    vecs[0] = '{8'd0,   8'd100, 1'b0, 4'd0, 4'd0, 20000, 200, 10000};
    vecs[1] = '{8'd255, 8'd255, 1'b0, 4'd0, 4'd0, 200,   200, 0};
    vecs[2] = '{8'd200, 8'd10,  1'b0, 4'd0, 4'd0, 4400,  20,  2200};
    vecs[3] = '{8'd250, 8'd0,   1'b0, 4'd0, 4'd0, 500,   0,   0};
    vecs[4] = '{8'd254, 8'd90,  1'b0, 4'd0, 4'd0, 188,   180, 94};
    vecs[5] = '{8'd128, 8'd100, 1'b1, 4'd2, 4'd3, 25040, 200, 5008};
    vecs[6] = '{8'd250, 8'd50,  1'b1, 4'd0, 4'd3, 1000,  0,   0};
    vecs[7] = '{8'd250, 8'd50,  1'b1, 4'd2, 4'd0, 1000,  200, 250};
    vecs[8] = '{8'd250, 8'd50,  1'b0, 4'd0, 4'd3, 500,   100, 250};

    #3;
    check("reset_outputs", int'({out_p, out_n, int_out, lockout, fault}), 0);

    for (int k = 0; k < 9; k++) begin
      rst_n = 1'b0; gen_auto = 1'b1; en = 1'b1;
      fp = vecs[k].fp; pw = vecs[k].pw; mode = vecs[k].mode;
      bon = vecs[k].bon; boff = vecs[k].boff;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      cnt = 0; rise = 0; prev = 1'b0; both = 0;
      for (int i = 0; i < vecs[k].win; i++) begin
        s = int_out;
        cnt += int'(s);
        if (i > 0 && s && !prev && rise == 0) rise = i;
        prev = s;
        both += int'(out_p & out_n);
        @(posedge clk); #1;
      end
      check($sformatf("v%0d_on_cycles", k), cnt, vecs[k].exp_cnt);
      check($sformatf("v%0d_first_rise", k), rise, vecs[k].exp_rise);
      check($sformatf("v%0d_both_high", k), both, 0);
    end

    // gate alignment and OCD lockout; window always open (period 55, pw clipped)
    gen_auto = 1'b0; gen_man = 1'b0;
    do_reset(8'd255, 8'd255);
    repeat (10) @(posedge clk); #1;
    check("pre_gen_outputs", int'({out_p, out_n}), 0);
    check("pre_gen_int_out", int'(int_out), 1);
    gen_cycle(p);
    check("gen_rise_out_p", int'(p), 1);
    check("gen_low_out_n", int'({out_p, out_n}), 1);

    ocd_pulse();
    @(posedge clk); #1;
    check("lockout_sync_lat", int'(lockout), 0);
    @(posedge clk); #1;
    check("lockout_rise", int'(lockout), 1);
    check("lockout_int_out", int'(int_out), 0);
    gen_cycle(p); check("skip1_out_p", int'(p), 0);
    gen_cycle(p); check("skip2_out_p", int'(p), 0);
    check("lockout_held", int'(lockout), 1);
    gen_cycle(p); check("skip3_out_p", int'(p), 0);
    check("lockout_exit", int'(lockout), 0);
    gen_cycle(p); check("resume_out_p", int'(p), 1);

    // clean periods clear the single trip; four fresh trips then latch FAULT
    repeat (200) @(posedge clk);
    @(negedge clk); gen_man = 1'b1;
    @(posedge clk); #1;
    check("pre_fault_out_p", int'(out_p), 1);
    ocd_pulse(); ocd_pulse(); ocd_pulse();
    repeat (3) @(posedge clk); #1;
    check("trip3_no_fault", int'(fault), 0);
    check("trip3_lockout", int'(lockout), 1);
    check("trip3_ff_held", int'(out_p), 1);
    ocd_pulse();
    @(posedge clk); #1;
    check("trip4_sync_lat", int'(fault), 0);
    @(posedge clk); #1;
    check("trip4_fault", int'(fault), 1);
    check("trip4_outputs", int'({out_p, out_n, lockout, int_out}), 0);

    @(negedge clk); ocd = 1'b1;
    repeat (3) @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk); fault_clr = 1'b0; #1;
    check("clr_ocd_high", int'(fault), 1);
    ocd = 1'b0;
    repeat (3) @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk); fault_clr = 1'b0; #1;
    check("clr_ocd_low", int'({fault, lockout}), 0);
    @(negedge clk); gen_man = 1'b0;
    repeat (2) @(negedge clk);
    gen_cycle(p); check("post_clr_out_p", int'(p), 1);

    // asynchronous reset mid-pulse
    @(negedge clk); gen_man = 1'b1;
    @(posedge clk); #3;
    check("pre_rst_out_p", int'(out_p), 1);
    rst_n = 1'b0; #1;
    check("async_rst_outputs", int'({out_p, out_n, int_out, lockout, fault}), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_int_out", int'(int_out), 1);
    check("rel_out_p", int'(out_p), 0);

    // disable, retune while idle, re-enable starts with a full window
    @(negedge clk); en = 1'b0; fp = 8'd254; pw = 8'd10;
    repeat (3) @(negedge clk); #1;
    check("en_off_int_out", int'(int_out), 0);
    en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 94; i++) begin
      #1 cnt += int'(int_out);
      @(negedge clk);
    end
    check("reen_window", cnt, 10);
    #1;
    check("reen_wrap", int'(int_out), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupter_burst.md
Name: interrupter_burst

Overview:
- Second-generation DRSSTC interrupter. Sits between the resonant-feedback comparator (gen) and the gate-driver outputs.
- The interrupter period is computed arithmetically instead of from a lookup table, and adds a burst (modulated) mode, an enable, an OCD trip counter with latched fault, and status outputs.
- Gate switching stays aligned to gen rising edges, giving zero-current switching.

Parameters:
- CLK_MHZ, 100, clock frequency in MHz.
- FREQ_MIN_HZ, 10_000, interrupter frequency at freq_par=0. FREQ_RATIO = CLK_MHZ*1_000_000/FREQ_MIN_HZ.
- PAR_MAX_VAL, 255, maximum freq_par/pw_par value. W_PAR = $clog2(PAR_MAX_VAL+1).
- PW_STEP_MUL, 1, clock cycles per pw_par LSB.
- SKIP_CNT_MAX, 3, gen rising edges suppressed after each OCD event.
- FAULT_TRIPS, 4, consecutive OCD trips that latch FAULT.
- BURST_MAX, 15, maximum burst_on/burst_off value. W_BURST = $clog2(BURST_MAX+1).
- SYNC_STAGES, 2, synchroniser depth on ocd (≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- gen  in  1  resonant feedback (primary current polarity).
- ocd  in  1  overcurrent detect, asynchronous, active-high.
- en  in  1  interrupter enable.
- mode  in  1  0 = continuous, 1 = burst.
- freq_par  in  W_PAR  interrupter frequency setting.
- pw_par  in  W_PAR  on-time setting.
- burst_on  in  W_BURST  interrupter periods on per burst.
- burst_off  in  W_BURST  interrupter periods off per burst.
- fault_clr  in  1  single-cycle fault clear.
- out_p  out  1  positive gate drive.
- out_n  out  1  negative gate drive.
- int_out  out  1  gated interrupter window (debug/LED).
- lockout  out  1  high in LOCKOUT state.
- fault  out  1  high in FAULT state.

Behaviour:
- Reset (rst_n=0, async): all outputs 0, state=RUN, skip_cnt=SKIP_CNT_MAX, trip_cnt=0, phase=0, burst_idx=0, all synchroniser/edge flops 0, latched parameters 0.
- ocd passes through a SYNC_STAGES flop chain to ocd_s. Latency from ocd to ocd_s is SYNC_STAGES cycles.
- Edge detection: gen_q <= gen. gen_rise = gen & ~gen_q.
- Period latching: period_lat = FREQ_RATIO - freq_par*PER_STEP, with PER_STEP = FREQ_RATIO/(PAR_MAX_VAL+1) (integer division).
  - pw_lat = min(pw_par*PW_STEP_MUL, period_lat).
  - Both are latched at reset release and whenever the phase wraps.
- Phase counter:
  - phase counts 0..period_lat-1, then wraps to 0 and relatches parameters.
  - int_on = phase < pw_lat.
  - en=0 holds phase=0 and burst_idx=0, so re-enable starts with an on-window.
- Burst counter (mode=1):
  - burst_idx increments on each phase wrap and wraps at burst_on+burst_off-1.
  - burst_act = burst_idx < burst_on.
  - burst_on=0 gives always off. burst_off=0 gives continuous.
  - mode=0 forces burst_act=1 and burst_idx=0.
- int_out = en & int_on & burst_act & (state==RUN).
- FSM:
  - RUN:
    - On gen_rise, ff <= int_out.
    - If ocd_s: go to LOCKOUT, skip_cnt <= SKIP_CNT_MAX, trip_cnt++. On a simultaneous gen_rise, ff <= 0.
    - A phase wrap with no ocd_s during that whole period clears trip_cnt.
  - LOCKOUT:
    - Each gen_rise: ff <= 0 and, if skip_cnt != 0, skip_cnt--.
    - ocd_s in this state reloads skip_cnt to SKIP_CNT_MAX and increments trip_cnt, once per ocd_s rising edge.
    - skip_cnt==0 & !ocd_s: go to RUN.
  - FAULT:
    - Entered from RUN or LOCKOUT the cycle trip_cnt reaches FAULT_TRIPS.
    - ff <= 0 immediately, not edge-aligned.
    - fault_clr & !ocd_s: go to RUN, trip_cnt=0, skip_cnt=SKIP_CNT_MAX.
  - fault_clr outside FAULT is ignored.
- trip_cnt saturates at FAULT_TRIPS.
- Outputs:
  - out_p = ff & gen_q; out_n = ff & ~gen_q. gen_q is gen delayed one cycle, matching the ff latency.
  - out_p and out_n are never both high.
  - lockout = (state==LOCKOUT); fault = (state==FAULT); both registered.
- Mid-operation parameter changes take effect only at the next phase wrap; no glitching within a period.

Test Plan:
- Continuous mode: freq_par=0, pw_par=100, en=1, gen 500 kHz square wave → int_out high for 100 of 10000 cycles; out_p/out_n toggle only within the window, starting on a gen rising edge.
- freq_par=255, pw_par=255 → period 55 cycles (10000-255*39); pw clipped to 55, so int_out stays high continuously.
- Burst mode: mode=1, burst_on=2, burst_off=3, freq_par=128 → pattern of 2 active periods then 3 silent periods repeats; burst_on=0 → outputs stay 0.
- Single 1-cycle ocd pulse in RUN → lockout rises SYNC_STAGES+1 cycles later; 3 gen rises are suppressed; RUN resumes on the 4th window; trip_cnt clears after one clean period.
- 4 ocd pulses inside consecutive lockouts → fault=1, outputs 0 at once; fault_clr while ocd high has no effect; fault_clr after ocd low → RUN.
- Assert rst_n=0 mid-pulse with out_p=1 → all outputs 0 asynchronously; after release the first on-window begins at phase 0.
